// File: rtl/dmem_responder_if.sv
// dmem_responder_if: MEM-stage data-memory request/response bundle.
// master = CPU memory stage, slave = dmem_responder.
interface dmem_responder_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        done_o;
  logic        stall_o;
  logic        err_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  rdata_o, done_o, stall_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output rdata_o, done_o, stall_o, err_o
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data memory for the MEM stage with stall.
// Optional misaligned-access check: define DMEM_ALIGN_CHK_EN.
module dmem_responder #(
  parameter int DEPTH_LOG2 = 5,
  parameter int LATENCY    = 3
) (
  input logic             clk_i,
  input logic             rst_i,
  dmem_responder_if.slave bus
);

  localparam int WORDS = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT =
    (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [3:0]              cnt;
  logic [3:0]              cnt_nxt;
  logic                    commit;
  logic                    misalign;
  logic [DEPTH_LOG2-1:0]   idx;
  logic [31:0]             rdata_q;
  logic [31:0]             mem [WORDS];
  logic                    unused_addr;

  assign idx = bus.addr_i[DEPTH_LOG2+1:2];

  // upper bits alias, low bits only matter to the alignment check
  assign unused_addr =
    ^{bus.addr_i[31:DEPTH_LOG2+2], bus.addr_i[1:0]};

`ifdef DMEM_ALIGN_CHK_EN
  logic err_q;

  assign misalign = |bus.addr_i[1:0];

  // remember whether the committed access was misaligned
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       err_q <= 1'b0;
    else if (commit) err_q <= misalign;
  end

  assign bus.err_o = (state == RESP) & err_q;
`else
  assign misalign  = 1'b0;
  assign bus.err_o = 1'b0;
`endif

  // state and BUSY counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // next state; commit marks the edge that enters RESP
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req_i) begin
          if (LATENCY == 1) begin
            state_nxt = RESP;
            commit    = 1'b1;
          end else begin
            state_nxt = BUSY;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
          commit    = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // load data register; misaligned accesses return zero
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= 32'd0;
    end else if (commit) begin
      if (misalign)        rdata_q <= 32'd0;
      else if (!bus.we_i)  rdata_q <= mem[idx];
    end
  end

  // array write; never while reset is held so aborted stores vanish
  always_ff @(posedge clk_i) begin
    if (commit && bus.we_i && !misalign && !rst_i)
      mem[idx] <= bus.wdata_i;
  end

  assign bus.rdata_o = rdata_q;
  assign bus.done_o  = (state == RESP);
  assign bus.stall_o = ((state == IDLE) & bus.req_i)
                     | (state == BUSY);

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder.
// Runs a LATENCY=3 and a LATENCY=1 instance side by side.
module tb_dmem_responder;

`ifdef DMEM_ALIGN_CHK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  exp_t        q3[$];
  exp_t        q1[$];
  logic [31:0] mem3 [32];
  logic [31:0] mem1 [32];
  logic [31:0] last3 = 32'd0;
  logic [31:0] last1 = 32'd0;

  dmem_responder_if if3 ();
  dmem_responder_if if1 ();

  dmem_responder #(.DEPTH_LOG2(5), .LATENCY(3)) u3 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if3)
  );

  dmem_responder #(.DEPTH_LOG2(5), .LATENCY(1)) u1 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if1)
  );

  always #5 clk = ~clk;

  // scoreboard: compare each completion against the queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && if3.done_o) begin
      tests++;
      if (q3.size() == 0) begin
        fails++;
        $display("FAIL u3 spurious done: no access outstanding");
      end else begin
        e = q3.pop_front();
        if (if3.rdata_o !== e.rdata || if3.err_o !== e.err) begin
          fails++;
          $display("FAIL u3 resp: rdata=%h err=%b required rdata=%h err=%b",
                   if3.rdata_o, if3.err_o, e.rdata, e.err);
        end
      end
    end
    if (!rst && if1.done_o) begin
      tests++;
      if (q1.size() == 0) begin
        fails++;
        $display("FAIL u1 spurious done: no access outstanding");
      end else begin
        e = q1.pop_front();
        if (if1.rdata_o !== e.rdata || if1.err_o !== e.err) begin
          fails++;
          $display("FAIL u1 resp: rdata=%h err=%b required rdata=%h err=%b",
                   if1.rdata_o, if1.err_o, e.rdata, e.err);
        end
      end
    end
  end

  // one access: push expectation, drive, check stall/done timing
  task automatic access(input bit one, input logic we,
                        input logic [31:0] addr,
                        input logic [31:0] wdata,
                        input string tag);
    int          lat;
    exp_t        e;
    logic [4:0]  i;
    bit          mis;
    logic        st;
    logic        dn;
    lat = one ? 1 : 3;
    i   = addr[6:2];
    mis = ALIGN && (addr[1:0] != 2'b00);
    if (mis) begin
      e.rdata = 32'd0;
      e.err   = 1'b1;
    end else if (we) begin
      if (one) mem1[i] = wdata; else mem3[i] = wdata;
      e.rdata = one ? last1 : last3;
      e.err   = 1'b0;
    end else begin
      e.rdata = one ? mem1[i] : mem3[i];
      e.err   = 1'b0;
    end
    if (one) begin
      last1 = e.rdata;
      q1.push_back(e);
      if1.we_i = we; if1.addr_i = addr; if1.wdata_i = wdata;
      if1.req_i = 1'b1;
    end else begin
      last3 = e.rdata;
      q3.push_back(e);
      if3.we_i = we; if3.addr_i = addr; if3.wdata_i = wdata;
      if3.req_i = 1'b1;
    end
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      st = one ? if1.stall_o : if3.stall_o;
      dn = one ? if1.done_o : if3.done_o;
      tests++;
      if (st !== 1'b1 || dn !== 1'b0) begin
        fails++;
        $display("FAIL %s hold cyc%0d: stall=%b done=%b required 1 0",
                 tag, k, st, dn);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    st = one ? if1.stall_o : if3.stall_o;
    dn = one ? if1.done_o : if3.done_o;
    tests++;
    if (st !== 1'b0 || dn !== 1'b1) begin
      fails++;
      $display("FAIL %s done cyc: stall=%b done=%b required 0 1",
               tag, st, dn);
    end
    @(posedge clk); #1;
    if (one) if1.req_i = 1'b0; else if3.req_i = 1'b0;
  endtask

  task automatic test_reset();
    if3.req_i = 1'b0; if3.we_i = 1'b0;
    if3.addr_i = '0; if3.wdata_i = '0;
    if1.req_i = 1'b0; if1.we_i = 1'b0;
    if1.addr_i = '0; if1.wdata_i = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if (if3.rdata_o !== 32'd0 || if3.done_o !== 1'b0 ||
        if3.err_o !== 1'b0 || if3.stall_o !== 1'b0) begin
      fails++;
      $display("FAIL reset u3: rdata=%h done=%b err=%b stall=%b required 0 0 0 0",
               if3.rdata_o, if3.done_o, if3.err_o, if3.stall_o);
    end
    tests++;
    if (if1.rdata_o !== 32'd0 || if1.done_o !== 1'b0 ||
        if1.stall_o !== 1'b0) begin
      fails++;
      $display("FAIL reset u1: rdata=%h done=%b stall=%b required 0 0 0",
               if1.rdata_o, if1.done_o, if1.stall_o);
    end
    if3.req_i = 1'b1;
    #1;
    tests++;
    if (if3.stall_o !== 1'b1) begin
      fails++;
      $display("FAIL reset stall follows req: stall=%b required 1",
               if3.stall_o);
    end
    if3.req_i = 1'b0;
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "st_10");
    access(1'b0, 1'b0, 32'h10, 32'h0, "ld_10");
  endtask

  task automatic test_alias();
    access(1'b0, 1'b1, 32'h80, 32'hCAFE0001, "st_80");
    access(1'b0, 1'b0, 32'h00, 32'h0, "ld_00_alias");
  endtask

  task automatic test_reset_mid();
    access(1'b0, 1'b1, 32'h20, 32'h0, "st_20_zero");
    access(1'b0, 1'b0, 32'h10, 32'h0, "ld_10_again");
    if3.we_i = 1'b1; if3.addr_i = 32'h20;
    if3.wdata_i = 32'h12345678; if3.req_i = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (if3.stall_o !== 1'b1) begin
      fails++;
      $display("FAIL midrst busy: stall=%b required 1", if3.stall_o);
    end
    if3.req_i = 1'b0;
    rst = 1'b1;
    #1;
    tests++;
    if (if3.stall_o !== 1'b0 || if3.done_o !== 1'b0 ||
        if3.rdata_o !== 32'd0) begin
      fails++;
      $display("FAIL midrst: stall=%b done=%b rdata=%h required 0 0 0",
               if3.stall_o, if3.done_o, if3.rdata_o);
    end
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (if3.done_o !== 1'b0 || if3.err_o !== 1'b0) begin
      fails++;
      $display("FAIL midrst hold: done=%b err=%b required 0 0",
               if3.done_o, if3.err_o);
    end
    rst = 1'b0;
    last3 = 32'd0;
    last1 = 32'd0;
    @(posedge clk); #1;
    access(1'b0, 1'b0, 32'h20, 32'h0, "ld_20_after_rst");
  endtask

  task automatic test_align();
    access(1'b0, 1'b1, 32'h13, 32'hFFFFFFFF, "st_13_mis");
    access(1'b0, 1'b0, 32'h10, 32'h0, "ld_10_chk");
    access(1'b0, 1'b0, 32'h12, 32'h0, "ld_12_mis");
  endtask

  task automatic test_back_to_back();
    access(1'b1, 1'b1, 32'h00, 32'h1, "l1_st_00");
    access(1'b1, 1'b1, 32'h04, 32'h2, "l1_st_04");
    access(1'b1, 1'b0, 32'h00, 32'h0, "l1_ld_00");
    access(1'b1, 1'b0, 32'h04, 32'h0, "l1_ld_04");
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_alias();
    test_reset_mid();
    test_align();
    test_back_to_back();
    repeat (3) @(posedge clk);
    tests++;
    if (q3.size() != 0 || q1.size() != 0) begin
      fails++;
      $display("FAIL drain: pending u3=%0d u1=%0d required 0 0",
               q3.size(), q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
